// File: rtl/dual_down_counter_if.sv
// rtl/dual_down_counter_if.sv - control/status bundle for the dual down-counter
interface dual_down_counter_if #(
    parameter int WIDTH = 64
);
    logic             En;
    logic             Slt;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             AutoReload;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;
    logic             Zero0;
    logic             Zero1;
    logic             Done0;
    logic             Done1;

    modport master (
        output En, Slt, Load, LoadVal, AutoReload,
        input  Output0, Output1, Zero0, Zero1, Done0, Done1
    );

    modport slave (
        input  En, Slt, Load, LoadVal, AutoReload,
        output Output0, Output1, Zero0, Zero1, Done0, Done1
    );
endinterface

// File: rtl/dual_down_counter.sv
// rtl/dual_down_counter.sv - two-channel countdown timer with prescaled channel 1
module dual_down_counter #(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    dual_down_counter_if.slave   bus
);
    localparam int              PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] cnt0, cnt1;
    logic [WIDTH-1:0] reload0, reload1;
    logic [PS_W-1:0]  psc;
    logic             done0, done1;
    logic             psc_last;

    // A count event at zero either reloads or holds; it never wraps.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cnt,
                                                    input logic [WIDTH-1:0] reload,
                                                    input logic             auto_reload);
        if (cnt != '0)
            return cnt - ONE;
        else if (auto_reload)
            return reload;
        else
            return cnt;
    endfunction

    assign psc_last = (psc == PS_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt0    <= '0;
            cnt1    <= '0;
            reload0 <= '0;
            reload1 <= '0;
            psc     <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (bus.Load) begin
                if (!bus.Slt) begin
                    cnt0    <= bus.LoadVal;
                    reload0 <= bus.LoadVal;
                end else begin
                    cnt1    <= bus.LoadVal;
                    reload1 <= bus.LoadVal;
                    psc     <= '0;
                end
            end else if (bus.En) begin
                if (!bus.Slt) begin
                    cnt0  <= next_count(cnt0, reload0, bus.AutoReload);
                    done0 <= (cnt0 == ONE);
                end else begin
                    // Prescaler keeps running even while channel 1 sits at zero.
                    psc <= psc_last ? '0 : psc + PS_W'(1);
                    if (psc_last) begin
                        cnt1  <= next_count(cnt1, reload1, bus.AutoReload);
                        done1 <= (cnt1 == ONE);
                    end
                end
            end
        end
    end

    assign bus.Output0 = cnt0;
    assign bus.Output1 = cnt1;
    assign bus.Zero0   = (cnt0 == '0);
    assign bus.Zero1   = (cnt1 == '0);
    assign bus.Done0   = done0;
    assign bus.Done1   = done1;
endmodule

// File: tb/tb_dual_down_counter.sv
// tb/tb_dual_down_counter.sv - directed self-checking bench for dual_down_counter
module tb_dual_down_counter;
    logic Clk;
    logic Reset;
    int   tests;
    int   failed;

    dual_down_counter_if #(.WIDTH(64)) bus();

    dual_down_counter #(.WIDTH(64), .PRESCALE(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [63:0] t2_out [4]  = '{64'd2, 64'd1, 64'd0, 64'd0};
    logic        t2_done[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] t3_out [8]  = '{64'd2, 64'd2, 64'd2, 64'd1, 64'd1, 64'd1, 64'd1, 64'd0};
    logic        t3_done[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] t4_out [6]  = '{64'd1, 64'd0, 64'd2, 64'd1, 64'd0, 64'd2};
    logic        t4_done[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] t5_out [4]  = '{64'd5, 64'd5, 64'd5, 64'd4};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic slt, input logic load,
                         input logic [63:0] val, input logic ar);
        bus.En         = en;
        bus.Slt        = slt;
        bus.Load       = load;
        bus.LoadVal    = val;
        bus.AutoReload = ar;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests  = 0;
        failed = 0;
        Reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        #3;
        chk("rst_out0", bus.Output0, 64'd0);
        chk("rst_out1", bus.Output1, 64'd0);
        chk("rst_zero0", bus.Zero0, 1'b1);
        chk("rst_zero1", bus.Zero1, 1'b1);
        chk("rst_done0", bus.Done0, 1'b0);
        chk("rst_done1", bus.Done1, 1'b0);
        tick();
        tick();
        Reset = 1'b1;

        // Channel 0 countdown from 3
        drive(1'b0, 1'b0, 1'b1, 64'd3, 1'b0);
        tick();
        chk("t2_load", bus.Output0, 64'd3);
        chk("t2_load_done", bus.Done0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_out0_%0d", i), bus.Output0, t2_out[i]);
            chk($sformatf("t2_done0_%0d", i), bus.Done0, t2_done[i]);
        end
        chk("t2_zero0", bus.Zero0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        tick();
        chk("t2_idle_done0", bus.Done0, 1'b0);

        // Channel 1 prescaled countdown from 2
        drive(1'b0, 1'b1, 1'b1, 64'd2, 1'b0);
        tick();
        chk("t3_load", bus.Output1, 64'd2);
        drive(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_out1_%0d", i), bus.Output1, t3_out[i]);
            chk($sformatf("t3_done1_%0d", i), bus.Done1, t3_done[i]);
            chk($sformatf("t3_out0_hold_%0d", i), bus.Output0, 64'd0);
        end
        chk("t3_zero1", bus.Zero1, 1'b1);

        // Auto-reload on channel 0
        drive(1'b0, 1'b0, 1'b1, 64'd2, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_out0_%0d", i), bus.Output0, t4_out[i]);
            chk($sformatf("t4_done0_%0d", i), bus.Done0, t4_done[i]);
        end

        // Load beats En on channel 1 and clears the prescaler (left at 2)
        drive(1'b0, 1'b1, 1'b1, 64'd9, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        tick();
        tick();
        chk("t5_pre_out1", bus.Output1, 64'd9);
        drive(1'b1, 1'b1, 1'b1, 64'd5, 1'b0);
        tick();
        chk("t5_load_out1", bus.Output1, 64'd5);
        chk("t5_out0_hold", bus.Output0, 64'd2);
        chk("t5_load_done1", bus.Done1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_out1_%0d", i), bus.Output1, t5_out[i]);
        end

        // All-ones start value and a zero load without auto-reload
        drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        tick();
        chk("t6_max_dec", bus.Output0, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b0, 1'b0, 1'b1, 64'd0, 1'b0);
        tick();
        chk("t6_load0_done", bus.Done0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_out0_%0d", i), bus.Output0, 64'd0);
            chk($sformatf("t6_done0_%0d", i), bus.Done0, 1'b0);
        end

        // Asynchronous reset in the middle of a countdown
        drive(1'b0, 1'b0, 1'b1, 64'd10, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        tick();
        tick();
        chk("t1_pre_out0", bus.Output0, 64'd8);
        chk("t1_pre_out1", bus.Output1, 64'd4);
        #2;
        Reset = 1'b0;
        #1;
        chk("t1_out0", bus.Output0, 64'd0);
        chk("t1_out1", bus.Output1, 64'd0);
        chk("t1_zero0", bus.Zero0, 1'b1);
        chk("t1_zero1", bus.Zero1, 1'b1);
        chk("t1_done0", bus.Done0, 1'b0);
        chk("t1_done1", bus.Done1, 1'b0);
        Reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        tick();
        chk("t1_reload0_cleared", bus.Output0, 64'd0);
        chk("t1_after_done0", bus.Done0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
